// File: rtl/rv_pkg.sv
// RV32IM opcode, funct7 and ALU operation index constants shared by decode and ALU.
// Also holds the instruction-word to ALU-op decoder used by the decode stage.
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [5:0] ALU_ADD     = 6'd0;
    localparam logic [5:0] ALU_SUB     = 6'd1;
    localparam logic [5:0] ALU_SLL     = 6'd2;
    localparam logic [5:0] ALU_SLT     = 6'd3;
    localparam logic [5:0] ALU_SLTU    = 6'd4;
    localparam logic [5:0] ALU_XOR     = 6'd5;
    localparam logic [5:0] ALU_SRL     = 6'd6;
    localparam logic [5:0] ALU_SRA     = 6'd7;
    localparam logic [5:0] ALU_OR      = 6'd8;
    localparam logic [5:0] ALU_AND     = 6'd9;
    localparam logic [5:0] ALU_MUL     = 6'd10;
    localparam logic [5:0] ALU_MULH    = 6'd11;
    localparam logic [5:0] ALU_MULHSU  = 6'd12;
    localparam logic [5:0] ALU_MULHU   = 6'd13;
    localparam logic [5:0] ALU_DIV     = 6'd14;
    localparam logic [5:0] ALU_DIVU    = 6'd15;
    localparam logic [5:0] ALU_REM     = 6'd16;
    localparam logic [5:0] ALU_REMU    = 6'd17;
    localparam logic [5:0] ALU_ADDI    = 6'd18;
    localparam logic [5:0] ALU_SLTI    = 6'd19;
    localparam logic [5:0] ALU_SLTIU   = 6'd20;
    localparam logic [5:0] ALU_XORI    = 6'd21;
    localparam logic [5:0] ALU_ORI     = 6'd22;
    localparam logic [5:0] ALU_ANDI    = 6'd23;
    localparam logic [5:0] ALU_SLLI    = 6'd24;
    localparam logic [5:0] ALU_SRLI    = 6'd25;
    localparam logic [5:0] ALU_SRAI    = 6'd26;
    localparam logic [5:0] ALU_LB      = 6'd27;
    localparam logic [5:0] ALU_LH      = 6'd28;
    localparam logic [5:0] ALU_LW      = 6'd29;
    localparam logic [5:0] ALU_LBU     = 6'd30;
    localparam logic [5:0] ALU_LHU     = 6'd31;
    localparam logic [5:0] ALU_SB      = 6'd32;
    localparam logic [5:0] ALU_SH      = 6'd33;
    localparam logic [5:0] ALU_SW      = 6'd34;
    localparam logic [5:0] ALU_BEQ     = 6'd35;
    localparam logic [5:0] ALU_BNE     = 6'd36;
    localparam logic [5:0] ALU_BLT     = 6'd37;
    localparam logic [5:0] ALU_BGE     = 6'd38;
    localparam logic [5:0] ALU_BLTU    = 6'd39;
    localparam logic [5:0] ALU_BGEU    = 6'd40;
    localparam logic [5:0] ALU_JAL     = 6'd41;
    localparam logic [5:0] ALU_JALR    = 6'd42;
    localparam logic [5:0] ALU_LUI     = 6'd43;
    localparam logic [5:0] ALU_AUIPC   = 6'd44;
    localparam logic [5:0] ALU_ILLEGAL = 6'd63;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] opc);
        case (opc)
            OPC_OP:                       return FMT_R;
            OPC_OPIMM, OPC_LOAD, OPC_JALR: return FMT_I;
            OPC_STORE:                    return FMT_S;
            OPC_BRANCH:                   return FMT_B;
            OPC_LUI, OPC_AUIPC:           return FMT_U;
            OPC_JAL:                      return FMT_J;
            default:                      return FMT_BAD;
        endcase
    endfunction

    function automatic logic [5:0] decode_op(input logic [31:0] ir);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] op;
        opc = ir[6:0];
        f3  = ir[14:12];
        f7  = ir[31:25];
        op  = ALU_ILLEGAL;
        case (opc)
            OPC_OP: begin
                if (f7 == F7_MULDIV) begin
                    op = ALU_MUL + {3'b000, f3};
                end else if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  op = ALU_ADD;
                        3'b001:  op = ALU_SLL;
                        3'b010:  op = ALU_SLT;
                        3'b011:  op = ALU_SLTU;
                        3'b100:  op = ALU_XOR;
                        3'b101:  op = ALU_SRL;
                        3'b110:  op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      op = ALU_SUB;
                    else if (f3 == 3'b101) op = ALU_SRA;
                end
            end
            OPC_OPIMM: begin
                case (f3)
                    3'b000:  op = ALU_ADDI;
                    3'b010:  op = ALU_SLTI;
                    3'b011:  op = ALU_SLTIU;
                    3'b100:  op = ALU_XORI;
                    3'b110:  op = ALU_ORI;
                    3'b111:  op = ALU_ANDI;
                    3'b001:  if (f7 == F7_BASE) op = ALU_SLLI;
                    default: begin
                        if (f7 == F7_BASE)     op = ALU_SRLI;
                        else if (f7 == F7_ALT) op = ALU_SRAI;
                    end
                endcase
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  op = ALU_LB;
                    3'b001:  op = ALU_LH;
                    3'b010:  op = ALU_LW;
                    3'b100:  op = ALU_LBU;
                    3'b101:  op = ALU_LHU;
                    default: op = ALU_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  op = ALU_SB;
                    3'b001:  op = ALU_SH;
                    3'b010:  op = ALU_SW;
                    default: op = ALU_ILLEGAL;
                endcase
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  op = ALU_BEQ;
                    3'b001:  op = ALU_BNE;
                    3'b100:  op = ALU_BLT;
                    3'b101:  op = ALU_BGE;
                    3'b110:  op = ALU_BLTU;
                    3'b111:  op = ALU_BGEU;
                    default: op = ALU_ILLEGAL;
                endcase
            end
            OPC_JAL:   op = ALU_JAL;
            OPC_JALR:  if (f3 == 3'b000) op = ALU_JALR;
            OPC_LUI:   op = ALU_LUI;
            OPC_AUIPC: op = ALU_AUIPC;
            default:   op = ALU_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch handshake, ALU bundle and writeback port of the decode stage.
// slave = the decode stage itself; master = the surrounding fetch/ALU/writeback logic.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            i_fetch_valid;
    logic            o_fetch_ready;
    logic [31:0]     i_fetch_instr;
    logic [XLEN-1:0] i_fetch_pc;
    logic            i_flush;
    logic            o_dec_valid;
    logic            i_dec_ready;
    logic [31:0]     o_instruction;
    logic [31:0]     o_IR;
    logic [XLEN-1:0] o_A;
    logic [XLEN-1:0] o_B;
    logic [XLEN-1:0] o_pc;
    logic            o_illegal;
    logic            i_wb_en;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;

    modport slave (
        input  i_fetch_valid, i_fetch_instr, i_fetch_pc, i_flush, i_dec_ready,
               i_wb_en, i_wb_rd, i_wb_data,
        output o_fetch_ready, o_dec_valid, o_instruction, o_IR, o_A, o_B, o_pc, o_illegal
    );

    modport master (
        output i_fetch_valid, i_fetch_instr, i_fetch_pc, i_flush, i_dec_ready,
               i_wb_en, i_wb_rd, i_wb_data,
        input  o_fetch_ready, o_dec_valid, o_instruction, o_IR, o_A, o_B, o_pc, o_illegal
    );
endinterface

// File: rtl/decode_stage_regfile.sv
// 2-read/1-write register file with x0 hardwired to zero and write-to-read bypass.
module decode_stage_regfile #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr0,
    output logic [XLEN-1:0] rd_data0,
    input  logic [AW-1:0]   rd_addr1,
    output logic [XLEN-1:0] rd_data1
);
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write to the addressed register wins over the stored value.
    always_comb begin
        rd_data0 = '0;
        if (rd_addr0 != '0) begin
            rd_data0 = (wr_en && wr_addr == rd_addr0) ? wr_data : regs[rd_addr0];
        end
    end

    always_comb begin
        rd_data1 = '0;
        if (rd_addr1 != '0) begin
            rd_data1 = (wr_en && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
        end
    end
endmodule

// File: rtl/decode_stage.sv
// RV32IM decode stage: accepts fetched words, decodes to an ALU op index and
// registers {op, IR, A, B, PC} for the ALU behind a valid/ready handshake.
module decode_stage
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic          i_clk,
    input logic          i_rst_n,
    decode_stage_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic            dec_valid;
    logic [31:0]     instruction;
    logic [31:0]     ir;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] pc;
    logic            illegal;

    logic            fetch_ready;
    logic            accept;
    logic [5:0]      op_next;
    fmt_e            fmt;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] b_next;

    assign fetch_ready = !dec_valid || bus.i_dec_ready;
    assign accept      = bus.i_fetch_valid && fetch_ready;

    decode_stage_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .wr_en    (bus.i_wb_en),
        .wr_addr  (bus.i_wb_rd[AW-1:0]),
        .wr_data  (bus.i_wb_data),
        .rd_addr0 (bus.i_fetch_instr[15 +: AW]),
        .rd_data0 (rs1_data),
        .rd_addr1 (bus.i_fetch_instr[20 +: AW]),
        .rd_data1 (rs2_data)
    );

    always_comb begin
        op_next = decode_op(bus.i_fetch_instr);
        fmt     = fmt_of(bus.i_fetch_instr[6:0]);
        a_next  = rs1_data;
        b_next  = '0;
        if (fmt == FMT_U || fmt == FMT_J) begin
            a_next = '0;
        end
        if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) begin
            b_next = rs2_data;
        end
    end

    // Flush outranks accept; data registers only load on a real accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dec_valid   <= 1'b0;
            instruction <= '0;
            ir          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            pc          <= RESET_PC;
            illegal     <= 1'b0;
        end else if (bus.i_flush) begin
            dec_valid <= 1'b0;
        end else if (accept) begin
            dec_valid   <= 1'b1;
            instruction <= 32'(op_next);
            ir          <= bus.i_fetch_instr;
            op_a        <= a_next;
            op_b        <= b_next;
            pc          <= bus.i_fetch_pc;
            illegal     <= (op_next == ALU_ILLEGAL);
        end else if (bus.i_dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

    assign bus.o_fetch_ready = fetch_ready;
    assign bus.o_dec_valid   = dec_valid;
    assign bus.o_instruction = instruction;
    assign bus.o_IR          = ir;
    assign bus.o_A           = op_a;
    assign bus.o_B           = op_b;
    assign bus.o_pc          = pc;
    assign bus.o_illegal     = illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table streamed back-to-back,
// plus hand-written stall, bypass, x0, flush and async-reset sequences.
module tb_decode_stage;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   div_issues = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(
        .XLEN     (32),
        .NREGS    (32),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] op;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] op,
                                input logic ill, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.instr = instr; v.op = op; v.ill = ill; v.a = a; v.b = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fetch(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.i_fetch_valid = v;
        bus.i_fetch_instr = instr;
        bus.i_fetch_pc    = pc;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.i_wb_en   = en;
        bus.i_wb_rd   = rd;
        bus.i_wb_data = data;
    endtask

    always @(posedge clk) begin
        if (bus.o_dec_valid && bus.i_dec_ready && bus.o_instruction == 32'd14) div_issues++;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // x1 = 3, x2 = 4 throughout the table
        vecs[0]  = mk(32'h002081B3, 32'd0,  1'b0, 32'd3, 32'd4);  // ADD
        vecs[1]  = mk(32'h402081B3, 32'd1,  1'b0, 32'd3, 32'd4);  // SUB
        vecs[2]  = mk(32'h022081B3, 32'd10, 1'b0, 32'd3, 32'd4);  // MUL
        vecs[3]  = mk(32'h0220C1B3, 32'd14, 1'b0, 32'd3, 32'd4);  // DIV
        vecs[4]  = mk(32'hFFFFFFFF, 32'd63, 1'b1, 32'd0, 32'd0);  // illegal
        vecs[5]  = mk(32'h4000D093, 32'd26, 1'b0, 32'd3, 32'd0);  // SRAI
        vecs[6]  = mk(32'h4000C093, 32'd21, 1'b0, 32'd3, 32'd0);  // XORI, imm[11:5]!=0
        vecs[7]  = mk(32'h40009093, 32'd63, 1'b1, 32'd3, 32'd0);  // SLLI with bad funct7
        vecs[8]  = mk(32'h0000A183, 32'd29, 1'b0, 32'd3, 32'd0);  // LW
        vecs[9]  = mk(32'h0000B183, 32'd63, 1'b1, 32'd3, 32'd0);  // load funct3=011
        vecs[10] = mk(32'h0020A023, 32'd34, 1'b0, 32'd3, 32'd4);  // SW
        vecs[11] = mk(32'h00208063, 32'd35, 1'b0, 32'd3, 32'd4);  // BEQ
        vecs[12] = mk(32'h000080EF, 32'd41, 1'b0, 32'd0, 32'd0);  // JAL, rs1 field = x1
        vecs[13] = mk(32'h000080B7, 32'd43, 1'b0, 32'd0, 32'd0);  // LUI, rs1 field = x1
        vecs[14] = mk(32'h00008017, 32'd44, 1'b0, 32'd0, 32'd0);  // AUIPC, rs1 field = x1
        vecs[15] = mk(32'h000080E7, 32'd42, 1'b0, 32'd3, 32'd0);  // JALR
        vecs[16] = mk(32'h4020D1B3, 32'd7,  1'b0, 32'd3, 32'd4);  // SRA

        drive_fetch(1'b0, '0, '0);
        drive_wb(1'b0, '0, '0);
        bus.i_flush     = 1'b0;
        bus.i_dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("reset_valid", 32'(bus.o_dec_valid), 32'd0);
        chk("reset_op", bus.o_instruction, 32'd0);
        chk("reset_ir", bus.o_IR, 32'd0);
        chk("reset_a", bus.o_A, 32'd0);
        chk("reset_b", bus.o_B, 32'd0);
        chk("reset_pc", bus.o_pc, RST_PC);
        chk("reset_ill", 32'(bus.o_illegal), 32'd0);
        chk("reset_fready", 32'(bus.o_fetch_ready), 32'd1);

        // ADDI x1,x0,5
        drive_fetch(1'b1, 32'h00500093, 32'h100);
        tick();
        chk("addi_valid", 32'(bus.o_dec_valid), 32'd1);
        chk("addi_op", bus.o_instruction, 32'd18);
        chk("addi_a", bus.o_A, 32'd0);
        chk("addi_b", bus.o_B, 32'd0);
        chk("addi_pc", bus.o_pc, 32'h100);

        // Consume without a new accept: valid falls, data holds
        drive_fetch(1'b0, '0, '0);
        drive_wb(1'b1, 5'd1, 32'd3);
        tick();
        chk("drain_valid", 32'(bus.o_dec_valid), 32'd0);
        chk("drain_op_hold", bus.o_instruction, 32'd18);
        chk("drain_pc_hold", bus.o_pc, 32'h100);
        drive_wb(1'b1, 5'd2, 32'd4);
        tick();
        drive_wb(1'b0, '0, '0);

        foreach (vecs[i]) begin
            drive_fetch(1'b1, vecs[i].instr, 32'h200 + 32'(i) * 4);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.o_dec_valid), 32'd1);
            chk($sformatf("vec%0d_op", i), bus.o_instruction, vecs[i].op);
            chk($sformatf("vec%0d_ill", i), 32'(bus.o_illegal), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_ir", i), bus.o_IR, vecs[i].instr);
            chk($sformatf("vec%0d_a", i), bus.o_A, vecs[i].a);
            chk($sformatf("vec%0d_b", i), bus.o_B, vecs[i].b);
            chk($sformatf("vec%0d_pc", i), bus.o_pc, 32'h200 + 32'(i) * 4);
        end
        drive_fetch(1'b0, '0, '0);
        tick();
        chk("post_table_valid", 32'(bus.o_dec_valid), 32'd0);

        // Stall: DIV held for 3 cycles while fetch offers ADD
        div_issues = 0;
        bus.i_dec_ready = 1'b0;
        drive_fetch(1'b1, 32'h0220C1B3, 32'h300);
        tick();
        chk("stall_valid", 32'(bus.o_dec_valid), 32'd1);
        chk("stall_op", bus.o_instruction, 32'd14);
        drive_fetch(1'b1, 32'h002081B3, 32'h304);
        #1;
        chk("stall_fready", 32'(bus.o_fetch_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_hold_valid", 32'(bus.o_dec_valid), 32'd1);
            chk("stall_hold_op", bus.o_instruction, 32'd14);
            chk("stall_hold_ir", bus.o_IR, 32'h0220C1B3);
            chk("stall_hold_a", bus.o_A, 32'd3);
            chk("stall_hold_b", bus.o_B, 32'd4);
            chk("stall_hold_pc", bus.o_pc, 32'h300);
            chk("stall_hold_fready", 32'(bus.o_fetch_ready), 32'd0);
        end
        drive_fetch(1'b0, '0, '0);
        bus.i_dec_ready = 1'b1;
        #1;
        chk("release_fready", 32'(bus.o_fetch_ready), 32'd1);
        tick();
        chk("release_valid", 32'(bus.o_dec_valid), 32'd0);
        chk("div_issued_once", 32'(div_issues), 32'd1);

        // Bypass: write x1 and read it in the same accepting cycle
        drive_wb(1'b1, 5'd1, 32'hDEADBEEF);
        drive_fetch(1'b1, 32'h00008113, 32'h600);
        tick();
        chk("bypass_a", bus.o_A, 32'hDEADBEEF);
        drive_wb(1'b0, '0, '0);
        tick();
        chk("bypass_stored_a", bus.o_A, 32'hDEADBEEF);

        // x0 ignores writes, both stored and bypassed
        drive_fetch(1'b0, '0, '0);
        drive_wb(1'b1, 5'd0, 32'h55);
        tick();
        drive_wb(1'b1, 5'd0, 32'h77);
        drive_fetch(1'b1, 32'h000001B3, 32'h610);
        tick();
        drive_wb(1'b0, '0, '0);
        chk("x0_a", bus.o_A, 32'd0);
        chk("x0_b", bus.o_B, 32'd0);

        // Flush together with an accept
        drive_fetch(1'b1, 32'h00500093, 32'h400);
        bus.i_flush = 1'b1;
        tick();
        chk("flush_acc_valid", 32'(bus.o_dec_valid), 32'd0);
        chk("flush_acc_pc", bus.o_pc, 32'h610);
        bus.i_flush = 1'b0;
        bus.i_dec_ready = 1'b0;
        drive_fetch(1'b1, 32'h000080B7, 32'h404);
        tick();
        chk("flush_held_pre", 32'(bus.o_dec_valid), 32'd1);
        drive_fetch(1'b0, '0, '0);
        bus.i_flush = 1'b1;
        #1;
        chk("flush_fready", 32'(bus.o_fetch_ready), 32'd0);
        tick();
        chk("flush_held_valid", 32'(bus.o_dec_valid), 32'd0);
        bus.i_flush = 1'b0;

        // Async reset while a bundle is held
        drive_fetch(1'b1, 32'h002081B3, 32'h500);
        tick();
        chk("rst_held_pre", 32'(bus.o_dec_valid), 32'd1);
        drive_fetch(1'b0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_dec_valid), 32'd0);
        chk("arst_op", bus.o_instruction, 32'd0);
        chk("arst_ir", bus.o_IR, 32'd0);
        chk("arst_a", bus.o_A, 32'd0);
        chk("arst_b", bus.o_B, 32'd0);
        chk("arst_pc", bus.o_pc, RST_PC);
        chk("arst_ill", 32'(bus.o_illegal), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.i_dec_ready = 1'b1;
        drive_fetch(1'b1, 32'h002081B3, 32'h504);
        tick();
        chk("arst_rf_a", bus.o_A, 32'd0);
        chk("arst_rf_b", bus.o_B, 32'd0);
        drive_fetch(1'b0, '0, '0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
